// File: rtl/data_memory.sv
// data_memory: multi-cycle byte/half/word data memory for the load/store unit.
// A request is latched in IDLE and completes LATENCY cycles later with a
// one-cycle ready pulse. Load data is right-justified and zero-filled.
// Misaligned accesses complete with err=1 and leave the array and rdata alone.
module data_memory #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [DEPTH];

    logic [ADDR_W-1:0]   idx;
    logic [4:0]          shamt;
    logic                misal;
    logic [3:0]          be;
    logic [31:0]         wword;
    logic [31:0]         rword;
    logic [31:0]         load_val;
    logic                complete;
    logic                mem_we;

    // Address bits above the array are ignored, so addresses wrap.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // Lane steering, alignment check and load extraction for the latched access.
    always_comb begin
        idx   = addr_q[ADDR_W+1:2];
        shamt = {addr_q[1:0], 3'b000};
        misal = 1'b0;
        be    = 4'b0000;
        case (size_q)
            2'b00: begin
                misal = 1'b0;
                be    = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                misal = addr_q[0];
                be    = 4'b0011 << addr_q[1:0];
            end
            default: begin
                misal = |addr_q[1:0];
                be    = 4'b1111;
            end
        endcase
        wword = wdata_q << shamt;
        rword = mem_q[idx] >> shamt;
        case (size_q)
            2'b00:   load_val = {24'h000000, rword[7:0]};
            2'b01:   load_val = {16'h0000, rword[15:0]};
            default: load_val = rword;
        endcase
    end

    // IDLE/BUSY sequencing: latch on request, count down, complete at zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = err_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    addr_d  = addr[ADDR_W+1:0];
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    ready_d  = 1'b1;
                    err_d    = misal;
                    if (!we_q && !misal) begin
                        rdata_d = load_val;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = complete && we_q && !misal;

    // Control and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array write on the completing edge, byte lanes selected by be.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: checks data_memory (LATENCY=4 and LATENCY=1 instances)
// against a byte-array reference model with directed and random accesses.
module tb_data_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;

    int          sel = 0;
    logic        req4, req1;
    logic [31:0] rdata4, rdata1;
    logic        ready4, ready1, busy4, busy1, err4, err1;
    logic [31:0] rdata_o;
    logic        ready_o, busy_o, err_o;

    assign req4    = req && (sel == 0);
    assign req1    = req && (sel == 1);
    assign rdata_o = (sel == 1) ? rdata1 : rdata4;
    assign ready_o = (sel == 1) ? ready1 : ready4;
    assign busy_o  = (sel == 1) ? busy1  : busy4;
    assign err_o   = (sel == 1) ? err1   : err4;

    data_memory #(.ADDR_W(8), .LATENCY(4)) dut (
        .clk(clk), .reset_in(reset_in), .req(req4), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata4), .ready(ready4),
        .busy(busy4), .err(err4)
    );

    data_memory #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset_in(reset_in), .req(req1), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .ready(ready1),
        .busy(busy1), .err(err1)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: one flat byte array per instance, 1024 bytes each.
    logic [7:0]  mdl [2][1024];
    logic [31:0] exp_rdata [2];

    function automatic int lat_of();
        return (sel == 1) ? 1 : 4;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(sz); i++) begin
            v = v | (32'(mdl[sel][(int'(a[9:0]) + i) % 1024]) << (8 * i));
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) begin
            mdl[sel][(int'(a[9:0]) + i) % 1024] = d[8*i +: 8];
        end
    endtask

    // Issue one access from an idle cycle and check it through completion.
    task automatic access(input bit w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input string nm);
        bit exp_e;
        int cyc;
        exp_e = misaligned(sz, a);
        req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); size = 2'($urandom);
        addr = $urandom; wdata = $urandom;
        cyc = 0;
        while (!ready_o && cyc < 40) begin
            tests_run++;
            if (busy_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s busy: got %b expected 1 (cycle %0d)", nm, busy_o, cyc);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!exp_e) begin
            if (w) model_store(sz, a, wd);
            else   exp_rdata[sel] = model_load(sz, a);
        end
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s timeout: ready got %b expected 1", nm, ready_o);
            return;
        end
        tests_run++;
        if (cyc !== lat_of()) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", nm, cyc, lat_of());
        end
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_with_ready: got %b expected 0", nm, busy_o);
        end
        tests_run++;
        if (err_o !== exp_e) begin
            tests_failed++;
            $display("FAIL %s err: got %b expected %b", nm, err_o, exp_e);
        end
        tests_run++;
        if (rdata_o !== exp_rdata[sel]) begin
            tests_failed++;
            $display("FAIL %s rdata: got %h expected %h", nm, rdata_o, exp_rdata[sel]);
        end
        @(posedge clk); #1;
        tests_run++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after_ready: got ready=%b busy=%b expected 0 0", nm, ready_o, busy_o);
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        #22;
        tests_run++;
        if ({rdata4, ready4, busy4, err4} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_l4: got rdata=%h ready=%b busy=%b err=%b expected all 0",
                     rdata4, ready4, busy4, err4);
        end
        tests_run++;
        if ({rdata1, ready1, busy1, err1} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_l1: got rdata=%h ready=%b busy=%b err=%b expected all 0",
                     rdata1, ready1, busy1, err1);
        end
        reset_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 256; i++) begin
                access(1'b1, 2'd2, 32'(i * 4), $urandom, "preload");
            end
        end
        sel = 0;
    endtask

    task automatic test_word();
        access(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, "word_store");
        access(1'b0, 2'd2, 32'h10, 32'h0, "word_load");
        tests_run++;
        if (rdata_o !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_value: got %h expected deadbeef", rdata_o);
        end
    endtask

    task automatic test_lanes();
        access(1'b1, 2'd2, 32'h20, 32'h11223344, "lane_word_store");
        access(1'b1, 2'd0, 32'h21, 32'hFFFFFFAA, "lane_byte_store");
        access(1'b1, 2'd1, 32'h22, 32'hFFFFBBCC, "lane_half_store");
        access(1'b0, 2'd2, 32'h20, 32'h0, "lane_word_load");
        tests_run++;
        if (rdata_o !== 32'hBBCCAA44) begin
            tests_failed++;
            $display("FAIL lane_word_value: got %h expected bbccaa44", rdata_o);
        end
        access(1'b0, 2'd0, 32'h21, 32'h0, "lane_byte_load");
        tests_run++;
        if (rdata_o !== 32'h000000AA) begin
            tests_failed++;
            $display("FAIL lane_byte_value: got %h expected 000000aa", rdata_o);
        end
        access(1'b0, 2'd1, 32'h22, 32'h0, "lane_half_load");
        tests_run++;
        if (rdata_o !== 32'h0000BBCC) begin
            tests_failed++;
            $display("FAIL lane_half_value: got %h expected 0000bbcc", rdata_o);
        end
    endtask

    task automatic test_misalign();
        access(1'b1, 2'd1, 32'h31, 32'h0000EEEE, "mis_half_store");
        access(1'b0, 2'd2, 32'h32, 32'h0, "mis_word_load");
        tests_run++;
        if (rdata_o !== 32'h0000BBCC) begin
            tests_failed++;
            $display("FAIL mis_rdata_held: got %h expected 0000bbcc", rdata_o);
        end
        access(1'b0, 2'd2, 32'h30, 32'h0, "mis_prior_contents");
    endtask

    task automatic test_back_to_back();
        int cyc;
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h50; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 0;
        @(posedge clk); #1;
        cyc++;
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h54; wdata = 32'h0BAD0BAD;
        @(posedge clk); #1;
        cyc++;
        req = 1'b0;
        while (!ready_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (ready_o !== 1'b1 || cyc !== 4) begin
            tests_failed++;
            $display("FAIL b2b_first_ready: got ready=%b at %0d expected 1 at 4", ready_o, cyc);
        end
        model_store(2'd2, 32'h50, 32'hCAFEF00D);
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h50;
        @(posedge clk); #1;
        req = 1'b0;
        tests_run++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: got busy=%b ready=%b expected 1 0", busy_o, ready_o);
        end
        cyc = 0;
        while (!ready_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        exp_rdata[0] = 32'hCAFEF00D;
        tests_run++;
        if (ready_o !== 1'b1 || cyc !== 4 || rdata_o !== 32'hCAFEF00D || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second: got ready=%b cyc=%0d rdata=%h err=%b expected 1 4 cafef00d 0",
                     ready_o, cyc, rdata_o, err_o);
        end
        @(posedge clk); #1;
        access(1'b0, 2'd2, 32'h54, 32'h0, "b2b_ignored_not_written");
    endtask

    task automatic test_reset_mid();
        req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h40; wdata = 32'h55;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_in = 1'b0;
        #1;
        tests_run++;
        if ({rdata4, ready4, busy4, err4} !== 35'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got rdata=%h ready=%b busy=%b err=%b expected all 0",
                     rdata4, ready4, busy4, err4);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (ready4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_no_ready: got %b expected 0", ready4);
            end
        end
        reset_in = 1'b1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(posedge clk); #1;
        access(1'b0, 2'd0, 32'h40, 32'h0, "rst_mid_old_value");
    endtask

    task automatic test_random(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            access(1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom, nm);
        end
    endtask

    task automatic test_wrap_min_latency();
        sel = 1;
        access(1'b1, 2'd2, 32'h404, 32'h13579BDF, "wrap_store");
        access(1'b0, 2'd2, 32'h004, 32'h0, "wrap_load");
        tests_run++;
        if (rdata_o !== 32'h13579BDF) begin
            tests_failed++;
            $display("FAIL wrap_value: got %h expected 13579bdf", rdata_o);
        end
        test_random(60, "random_l1");
        sel = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_word();
        test_lanes();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random(200, "random_l4");
        test_wrap_min_latency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
